// File: rtl/mul_sequencer.sv
// Sequencer for a 3-product 16x16 multiplier cell: MUL takes one pass through the cell,
// MULXUU takes a second pass on the upper halves and folds the carries into a 64-bit sum.
module mul_sequencer #(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE1, S_CAP1, S_ISSUE2, S_CAP2, S_DONE
  } state_t;

  localparam logic [2:0] LAST = 3'(CELL_LATENCY - 1);

  state_t      r_state, w_next;
  logic        r_op;
  logic [2:0]  r_cnt;
  logic [31:0] r_p1, r_p2, r_p3, r_p4;
  logic [31:0] r_cell_src1, r_cell_src2;
  logic        w_cnt_done;
  logic [32:0] w_mid, w_lo;
  logic [31:0] w_hi;

  assign w_cnt_done = (r_cnt == LAST);

  // Result is formed from captured products, so it is zero after reset and
  // stays constant for as long as DONE is held.
  assign w_mid = {1'b0, r_p2} + {1'b0, r_p3};
  assign w_lo  = {1'b0, r_p1} + {1'b0, w_mid[15:0], 16'h0};
  assign w_hi  = r_p4 + {15'h0, w_mid[32:16]} + {31'h0, w_lo[32]};

  assign out_result = r_op ? w_hi : w_lo[31:0];
  assign cell_src1  = r_cell_src1;
  assign cell_src2  = r_cell_src2;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    cell_en   = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ISSUE1;
      end
      S_ISSUE1: begin
        cell_en = 1'b1;
        if (w_cnt_done) w_next = S_CAP1;
      end
      S_CAP1:   w_next = r_op ? S_ISSUE2 : S_DONE;
      S_ISSUE2: begin
        cell_en = 1'b1;
        if (w_cnt_done) w_next = S_CAP2;
      end
      S_CAP2:   w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 1'b0;
      r_cnt       <= '0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_p3        <= '0;
      r_p4        <= '0;
      r_cell_src1 <= '0;
      r_cell_src2 <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op        <= in_op;
            r_cell_src1 <= in_src1;
            r_cell_src2 <= in_src2;
            r_cnt       <= '0;
          end
        end
        S_ISSUE1, S_ISSUE2: r_cnt <= w_cnt_done ? 3'd0 : r_cnt + 3'd1;
        S_CAP1: begin
          r_p1 <= cell_p1;
          r_p2 <= cell_p2;
          r_p3 <= cell_p3;
          // Second pass reuses the lo*lo lane on the upper halves to get hi*hi.
          if (r_op) begin
            r_cell_src1 <= {16'h0, r_cell_src1[31:16]};
            r_cell_src2 <= {16'h0, r_cell_src2[31:16]};
          end
        end
        S_CAP2: r_p4 <= cell_p1;
        default: ;
      endcase
    end
  end

endmodule
